// File: rtl/axi4_to_axil_bridge_if.sv
// AXI4 (full) and AXI4-Lite bus bundles used on the two sides of the bridge.

interface axi4_if #(
   parameter int ADDR_W = 40,
   parameter int DATA_W = 128,
   parameter int ID_W   = 16
) ();
   logic [ID_W-1:0]     awid;
   logic [ADDR_W-1:0]   awaddr;
   logic [7:0]          awlen;
   logic [2:0]          awsize;
   logic [1:0]          awburst;
   logic                awvalid, awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wlast, wvalid, wready;
   logic [ID_W-1:0]     bid;
   logic [1:0]          bresp;
   logic                bvalid, bready;
   logic [ID_W-1:0]     arid;
   logic [ADDR_W-1:0]   araddr;
   logic [7:0]          arlen;
   logic [2:0]          arsize;
   logic [1:0]          arburst;
   logic                arvalid, arready;
   logic [ID_W-1:0]     rid;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rlast, rvalid, rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready
   );
   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );
endinterface

interface axil_if #(
   parameter int ADDR_W = 40,
   parameter int DATA_W = 128
) ();
   logic [ADDR_W-1:0]   awaddr;
   logic [2:0]          awprot;
   logic                awvalid, awready;
   logic [DATA_W-1:0]   wdata;
   logic [DATA_W/8-1:0] wstrb;
   logic                wvalid, wready;
   logic [1:0]          bresp;
   logic                bvalid, bready;
   logic [ADDR_W-1:0]   araddr;
   logic [2:0]          arprot;
   logic                arvalid, arready;
   logic [DATA_W-1:0]   rdata;
   logic [1:0]          rresp;
   logic                rvalid, rready;

   modport master (
      output awaddr, awprot, awvalid, input awready,
      output wdata, wstrb, wvalid, input wready,
      input  bresp, bvalid, output bready,
      output araddr, arprot, arvalid, input arready,
      input  rdata, rresp, rvalid, output rready
   );
   modport slave (
      input  awaddr, awprot, awvalid, output awready,
      input  wdata, wstrb, wvalid, output wready,
      output bresp, bvalid, input bready,
      input  araddr, arprot, arvalid, output arready,
      output rdata, rresp, rvalid, input rready
   );
endinterface

// File: rtl/axi4_to_axil_bridge.sv
// AXI4 -> AXI4-Lite bridge: splits bursts into single Lite beats, rebases
// addresses by DEC_S_ADDR, merges write responses, regenerates rid/rlast.

module axi4_to_axil_bridge #(
   parameter int              ADDR_W     = 40,
   parameter int              DATA_W     = 128,
   parameter int              ID_W       = 16,
   parameter logic [ADDR_W-1:0] DEC_S_ADDR = 40'h00_A000_0000
) (
   input  logic    aclk,
   input  logic    aresetn,
   axi4_if.slave   s_axi,
   axil_if.master  m_axi
);
   localparam int STRB_W = DATA_W / 8;

   typedef struct packed {
      logic [ID_W-1:0]   id;
      logic [ADDR_W-1:0] addr;
      logic [7:0]        len;
      logic [2:0]        size;
      logic [1:0]        burst;
   } cmd_t;

   // FIXED keeps the address; INCR and WRAP both step by the beat size.
   function automatic logic [ADDR_W-1:0] next_addr(input cmd_t c);
      return (c.burst == 2'b00) ? c.addr : c.addr + (ADDR_W'(1) << c.size);
   endfunction

   typedef enum logic [2:0] {W_IDLE, W_DATA, W_ISSUE, W_RESP, W_BRESP} w_state_t;
   typedef enum logic [1:0] {R_IDLE, R_ISSUE, R_WAIT, R_DATA} r_state_t;

   w_state_t              w_state, w_next;
   cmd_t                  w_cmd;
   logic [7:0]            w_cnt;
   logic [1:0]            acc_resp;
   logic [DATA_W-1:0]     w_data;
   logic [STRB_W-1:0]     w_strb;
   logic                  aw_done, wd_done;

   r_state_t              r_state, r_next;
   cmd_t                  r_cmd;
   logic [7:0]            r_cnt;
   logic [DATA_W-1:0]     r_data;
   logic [1:0]            r_resp;

   // Beat count comes from awlen only; wlast carries no information here.
   logic unused_wlast;
   assign unused_wlast = s_axi.wlast;

   // ---------------- write path ----------------

   // Write state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) w_state <= W_IDLE;
      else          w_state <= w_next;
   end

   // Write next-state; AW and W Lite handshakes may finish in either order.
   always_comb begin
      w_next = w_state;
      case (w_state)
         W_IDLE:  if (s_axi.awvalid) w_next = W_DATA;
         W_DATA:  if (s_axi.wvalid)  w_next = W_ISSUE;
         W_ISSUE: if ((aw_done || m_axi.awready) && (wd_done || m_axi.wready)) w_next = W_RESP;
         W_RESP:  if (m_axi.bvalid)  w_next = (w_cnt == w_cmd.len) ? W_BRESP : W_DATA;
         W_BRESP: if (s_axi.bready)  w_next = W_IDLE;
         default: w_next = W_IDLE;
      endcase
   end

   // Write handshake outputs, decoded from state and done flags only.
   always_comb begin
      s_axi.awready = (w_state == W_IDLE);
      s_axi.wready  = (w_state == W_DATA);
      m_axi.awvalid = (w_state == W_ISSUE) && !aw_done;
      m_axi.wvalid  = (w_state == W_ISSUE) && !wd_done;
      m_axi.bready  = (w_state == W_RESP);
      s_axi.bvalid  = (w_state == W_BRESP);
   end

   // Write datapath: command latch, beat payload, response merge, address step.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         w_cmd    <= '0;
         w_cnt    <= '0;
         acc_resp <= '0;
         w_data   <= '0;
         w_strb   <= '0;
         aw_done  <= 1'b0;
         wd_done  <= 1'b0;
      end else begin
         case (w_state)
            W_IDLE: if (s_axi.awvalid) begin
               w_cmd.id    <= s_axi.awid;
               w_cmd.addr  <= s_axi.awaddr - DEC_S_ADDR;
               w_cmd.len   <= s_axi.awlen;
               w_cmd.size  <= s_axi.awsize;
               w_cmd.burst <= s_axi.awburst;
               w_cnt       <= '0;
               acc_resp    <= 2'b00;
            end
            W_DATA: if (s_axi.wvalid) begin
               w_data  <= s_axi.wdata;
               w_strb  <= s_axi.wstrb;
               aw_done <= 1'b0;
               wd_done <= 1'b0;
            end
            W_ISSUE: begin
               if (m_axi.awready) aw_done <= 1'b1;
               if (m_axi.wready)  wd_done <= 1'b1;
            end
            W_RESP: if (m_axi.bvalid) begin
               // Encoding order makes DECERR > SLVERR > OKAY a plain max.
               if (m_axi.bresp > acc_resp) acc_resp <= m_axi.bresp;
               if (w_cnt != w_cmd.len) begin
                  w_cnt      <= w_cnt + 8'd1;
                  w_cmd.addr <= next_addr(w_cmd);
               end
            end
            default: ;
         endcase
      end
   end

   assign m_axi.awaddr = w_cmd.addr;
   assign m_axi.awprot = 3'b000;
   assign m_axi.wdata  = w_data;
   assign m_axi.wstrb  = w_strb;
   assign s_axi.bid    = w_cmd.id;
   assign s_axi.bresp  = acc_resp;

   // ---------------- read path ----------------

   // Read state register.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) r_state <= R_IDLE;
      else          r_state <= r_next;
   end

   // Read next-state: one Lite read per AXI4 beat.
   always_comb begin
      r_next = r_state;
      case (r_state)
         R_IDLE:  if (s_axi.arvalid) r_next = R_ISSUE;
         R_ISSUE: if (m_axi.arready) r_next = R_WAIT;
         R_WAIT:  if (m_axi.rvalid)  r_next = R_DATA;
         R_DATA:  if (s_axi.rready)  r_next = (r_cnt == r_cmd.len) ? R_IDLE : R_ISSUE;
         default: r_next = R_IDLE;
      endcase
   end

   // Read handshake outputs and regenerated rlast.
   always_comb begin
      s_axi.arready = (r_state == R_IDLE);
      m_axi.arvalid = (r_state == R_ISSUE);
      m_axi.rready  = (r_state == R_WAIT);
      s_axi.rvalid  = (r_state == R_DATA);
      s_axi.rlast   = (r_state == R_DATA) && (r_cnt == r_cmd.len);
   end

   // Read datapath: command latch, beat capture, address step.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_cmd  <= '0;
         r_cnt  <= '0;
         r_data <= '0;
         r_resp <= '0;
      end else begin
         case (r_state)
            R_IDLE: if (s_axi.arvalid) begin
               r_cmd.id    <= s_axi.arid;
               r_cmd.addr  <= s_axi.araddr - DEC_S_ADDR;
               r_cmd.len   <= s_axi.arlen;
               r_cmd.size  <= s_axi.arsize;
               r_cmd.burst <= s_axi.arburst;
               r_cnt       <= '0;
            end
            R_WAIT: if (m_axi.rvalid) begin
               r_data <= m_axi.rdata;
               r_resp <= m_axi.rresp;
            end
            R_DATA: if (s_axi.rready && (r_cnt != r_cmd.len)) begin
               r_cnt      <= r_cnt + 8'd1;
               r_cmd.addr <= next_addr(r_cmd);
            end
            default: ;
         endcase
      end
   end

   assign m_axi.araddr = r_cmd.addr;
   assign m_axi.arprot = 3'b000;
   assign s_axi.rid    = r_cmd.id;
   assign s_axi.rdata  = r_data;
   assign s_axi.rresp  = r_resp;

endmodule

// File: tb/tb_axi4_to_axil_bridge.sv
// Directed bench for axi4_to_axil_bridge: vector table plus hand sequences
// for concurrency and mid-burst reset; a reactive Lite slave records traffic.
`timescale 1ns/1ps

module tb_axi4_to_axil_bridge;
   localparam int ADDR_W = 40;
   localparam int DATA_W = 128;
   localparam int ID_W   = 16;
   localparam int TMO    = 200;
   localparam logic [39:0] BASE = 40'h00_A000_0000;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi4_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) s_axi();
   axil_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W))              m_axi();

   axi4_to_axil_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .DEC_S_ADDR(BASE)) dut (
      .aclk(aclk), .aresetn(aresetn), .s_axi(s_axi), .m_axi(m_axi));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge aclk) cyc <= cyc + 1;

   typedef struct {
      bit          rd;
      logic [15:0] id;
      logic [39:0] addr;
      logic [7:0]  len;
      logic [2:0]  size;
      logic [1:0]  burst;
      logic [15:0] strb;
      logic [15:0] resps;    // slave response per Lite beat, 2 bits each
      int          aw_dly;   // Lite awready delay in cycles
      int          hold;     // cycles the AXI4 master withholds bready/rready
      int          exp_lat;  // 0 = not checked
      logic [39:0] exp_a0;
      logic [39:0] exp_step;
      logic [1:0]  exp_bresp;
   } vec_t;

   function automatic vec_t mkv(bit rd, logic [15:0] id, logic [39:0] addr, logic [7:0] len,
                                logic [2:0] size, logic [1:0] burst, logic [15:0] strb,
                                logic [15:0] resps, int aw_dly, int hold, int exp_lat,
                                logic [39:0] a0, logic [39:0] step, logic [1:0] bresp);
      vec_t v;
      v.rd = rd; v.id = id; v.addr = addr; v.len = len; v.size = size; v.burst = burst;
      v.strb = strb; v.resps = resps; v.aw_dly = aw_dly; v.hold = hold; v.exp_lat = exp_lat;
      v.exp_a0 = a0; v.exp_step = step; v.exp_bresp = bresp;
      return v;
   endfunction

   function automatic logic [127:0] wd(int k);
      return 128'h1234 | (128'(k) << 96);
   endfunction

   function automatic logic [127:0] lite_rd(int k);
      return {32'(k), 32'hDEAD_BEEF, 32'(k * 3 + 1), 32'h0000_5A5A};
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- Lite slave model ----------------
   logic [15:0]  b_resp_cfg = '0, r_resp_cfg = '0;
   int           aw_dly_cfg = 0;
   int           nb = 0, nr = 0, aw_wait = 0;
   logic [39:0]  aw_first;
   logic [39:0]  la_aw[$], la_ar[$];
   logic [127:0] lw_data[$];
   logic [15:0]  lw_strb[$];

   always @(negedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         m_axi.awready = 0; m_axi.wready = 0; m_axi.bvalid = 0; m_axi.bresp = 0;
         m_axi.arready = 0; m_axi.rvalid = 0; m_axi.rdata = 0; m_axi.rresp = 0;
         aw_wait = 0;
      end else begin
         if (m_axi.awvalid && !m_axi.awready) begin
            if (aw_wait == 0) aw_first = m_axi.awaddr;
            if (aw_wait >= aw_dly_cfg) begin
               m_axi.awready = 1;
               la_aw.push_back(m_axi.awaddr);
               if (aw_dly_cfg > 0) chk("lite awaddr stable", m_axi.awaddr, aw_first);
               aw_wait = 0;
            end else aw_wait++;
         end else m_axi.awready = 0;
         if (m_axi.wvalid && !m_axi.wready) begin
            m_axi.wready = 1;
            lw_data.push_back(m_axi.wdata);
            lw_strb.push_back(m_axi.wstrb);
         end else m_axi.wready = 0;
         if (m_axi.bready && !m_axi.bvalid) begin
            m_axi.bvalid = 1;
            m_axi.bresp  = b_resp_cfg[2*(nb%8) +: 2];
            nb++;
         end else m_axi.bvalid = 0;
         if (m_axi.arvalid && !m_axi.arready) begin
            m_axi.arready = 1;
            la_ar.push_back(m_axi.araddr);
         end else m_axi.arready = 0;
         if (m_axi.rready && !m_axi.rvalid) begin
            m_axi.rvalid = 1;
            m_axi.rdata  = lite_rd(nr);
            m_axi.rresp  = r_resp_cfg[2*(nr%8) +: 2];
            nr++;
         end else m_axi.rvalid = 0;
      end
   end

   task automatic clear_books();
      la_aw.delete(); la_ar.delete(); lw_data.delete(); lw_strb.delete();
      nb = 0; nr = 0;
   endtask

   // ---------------- AXI4 master tasks (start and end on a negedge) ----------------
   task automatic run_write(input vec_t v, input string tag, output int t_acc);
      int n, t0;
      s_axi.awid = v.id; s_axi.awaddr = v.addr; s_axi.awlen = v.len;
      s_axi.awsize = v.size; s_axi.awburst = v.burst; s_axi.awvalid = 1;
      n = 0;
      while (!s_axi.awready && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) chk({tag, " aw timeout"}, 1, 0);
      t0 = cyc; t_acc = t0;
      @(negedge aclk); s_axi.awvalid = 0;
      for (int k = 0; k <= int'(v.len); k++) begin
         s_axi.wdata = wd(k); s_axi.wstrb = v.strb; s_axi.wlast = (k == int'(v.len)); s_axi.wvalid = 1;
         n = 0;
         while (!s_axi.wready && n < TMO) begin @(negedge aclk); n++; end
         if (n >= TMO) chk({tag, " w timeout"}, 1, 0);
         @(negedge aclk); s_axi.wvalid = 0;
      end
      n = 0;
      while (!s_axi.bvalid && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) chk({tag, " b timeout"}, 1, 0);
      if (v.exp_lat != 0) chk({tag, " b latency"}, cyc - t0, v.exp_lat);
      for (int h = 0; h < v.hold; h++) begin
         @(negedge aclk);
         chk({tag, " b held"}, {s_axi.bvalid, s_axi.bid, s_axi.bresp}, {1'b1, v.id, v.exp_bresp});
      end
      chk({tag, " bid"}, s_axi.bid, v.id);
      chk({tag, " bresp"}, s_axi.bresp, v.exp_bresp);
      s_axi.bready = 1;
      @(negedge aclk); s_axi.bready = 0;
      chk({tag, " bvalid dropped"}, s_axi.bvalid, 0);
      chk({tag, " lite aw count"}, la_aw.size(), int'(v.len) + 1);
      chk({tag, " lite w count"}, lw_data.size(), int'(v.len) + 1);
      for (int k = 0; k < la_aw.size() && k < lw_data.size(); k++) begin
         chk($sformatf("%s lite awaddr[%0d]", tag, k), la_aw[k], 40'(v.exp_a0 + 40'(k) * v.exp_step));
         chk($sformatf("%s lite wdata[%0d]", tag, k), lw_data[k], wd(k));
         chk($sformatf("%s lite wstrb[%0d]", tag, k), lw_strb[k], v.strb);
      end
   endtask

   task automatic run_read(input vec_t v, input string tag, output int t_acc);
      int n, tp;
      logic [1:0] er;
      s_axi.arid = v.id; s_axi.araddr = v.addr; s_axi.arlen = v.len;
      s_axi.arsize = v.size; s_axi.arburst = v.burst; s_axi.arvalid = 1;
      n = 0;
      while (!s_axi.arready && n < TMO) begin @(negedge aclk); n++; end
      if (n >= TMO) chk({tag, " ar timeout"}, 1, 0);
      tp = cyc; t_acc = tp;
      @(negedge aclk); s_axi.arvalid = 0;
      for (int k = 0; k <= int'(v.len); k++) begin
         n = 0;
         while (!s_axi.rvalid && n < TMO) begin @(negedge aclk); n++; end
         if (n >= TMO) chk({tag, " r timeout"}, 1, 0);
         if (v.exp_lat != 0) chk($sformatf("%s r latency[%0d]", tag, k), cyc - tp, (k == 0) ? v.exp_lat : 3);
         tp = cyc;
         er = v.resps[2*k +: 2];
         for (int h = 0; h < v.hold; h++) begin
            @(negedge aclk);
            chk($sformatf("%s r held[%0d]", tag, k), {s_axi.rvalid, s_axi.rdata}, {1'b1, lite_rd(k)});
         end
         chk($sformatf("%s rid[%0d]", tag, k), s_axi.rid, v.id);
         chk($sformatf("%s rdata[%0d]", tag, k), s_axi.rdata, lite_rd(k));
         chk($sformatf("%s rresp[%0d]", tag, k), s_axi.rresp, er);
         chk($sformatf("%s rlast[%0d]", tag, k), s_axi.rlast, (k == int'(v.len)));
         s_axi.rready = 1;
         @(negedge aclk); s_axi.rready = 0;
      end
      chk({tag, " rvalid dropped"}, s_axi.rvalid, 0);
      chk({tag, " lite ar count"}, la_ar.size(), int'(v.len) + 1);
      for (int k = 0; k < la_ar.size(); k++)
         chk($sformatf("%s lite araddr[%0d]", tag, k), la_ar[k], 40'(v.exp_a0 + 40'(k) * v.exp_step));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[9];
      vec_t vw, vr;
      int tw, tr, n;
      // rd id       addr             len sz bu strb      resps  awd hold lat  a0               step        bresp
      vt[0] = mkv(0, 16'h0011, 40'h00_A000_0010, 0, 4, 1, 16'hFFFF, 16'h0000, 0, 0, 4,  40'h10,           40'h10, 2'd0);
      vt[1] = mkv(0, 16'h0022, 40'h00_A000_0000, 3, 4, 1, 16'hFFFF, 16'h0020, 0, 0, 13, 40'h00,           40'h10, 2'd2);
      vt[2] = mkv(1, 16'h005A, 40'h00_A000_0100, 2, 4, 0, 16'hFFFF, 16'h0008, 0, 0, 3,  40'h100,          40'h00, 2'd0);
      vt[3] = mkv(0, 16'h0033, 40'h00_A000_0040, 1, 2, 2, 16'h0F0F, 16'h000E, 0, 0, 7,  40'h40,           40'h04, 2'd3);
      vt[4] = mkv(1, 16'h0044, 40'h00_A000_0008, 1, 3, 1, 16'hFFFF, 16'h0004, 0, 0, 3,  40'h08,           40'h08, 2'd0);
      vt[5] = mkv(0, 16'h0055, 40'h00_0000_0010, 0, 4, 1, 16'h00FF, 16'h0001, 0, 0, 4,  40'hFF_6000_0010, 40'h10, 2'd1);
      vt[6] = mkv(1, 16'h0066, 40'h00_9FFF_FFF0, 1, 4, 1, 16'hFFFF, 16'h0000, 0, 0, 3,  40'hFF_FFFF_FFF0, 40'h10, 2'd0);
      vt[7] = mkv(0, 16'h0077, 40'h00_A000_0200, 1, 4, 1, 16'hFFFF, 16'h0000, 3, 5, 0,  40'h200,          40'h10, 2'd0);
      vt[8] = mkv(1, 16'h0088, 40'h00_A000_0300, 2, 4, 1, 16'hFFFF, 16'h0010, 0, 5, 0,  40'h300,          40'h10, 2'd0);

      s_axi.awvalid = 0; s_axi.wvalid = 0; s_axi.bready = 0; s_axi.arvalid = 0; s_axi.rready = 0;
      s_axi.awid = 0; s_axi.awaddr = 0; s_axi.awlen = 0; s_axi.awsize = 0; s_axi.awburst = 0;
      s_axi.wdata = 0; s_axi.wstrb = 0; s_axi.wlast = 0;
      s_axi.arid = 0; s_axi.araddr = 0; s_axi.arlen = 0; s_axi.arsize = 0; s_axi.arburst = 0;

      // Reset state
      repeat (2) @(negedge aclk);
      chk("reset s ready", {s_axi.awready, s_axi.arready, s_axi.wready}, 3'b110);
      chk("reset valids", {s_axi.bvalid, s_axi.rvalid, m_axi.awvalid, m_axi.wvalid, m_axi.arvalid}, 5'b0);
      chk("reset m ready", {m_axi.bready, m_axi.rready}, 2'b0);
      chk("reset payload", {s_axi.bid, s_axi.rid, s_axi.bresp, s_axi.rresp, s_axi.rlast}, 37'b0);
      chk("reset data", s_axi.rdata | m_axi.wdata, 128'h0);
      chk("reset addr", {m_axi.awaddr, m_axi.araddr, m_axi.awprot, m_axi.arprot}, 86'h0);
      #2 aresetn = 1;
      @(negedge aclk);

      // Table-driven vectors
      for (int i = 0; i < 9; i++) begin
         clear_books();
         b_resp_cfg = vt[i].resps; r_resp_cfg = vt[i].resps; aw_dly_cfg = vt[i].aw_dly;
         if (vt[i].rd) run_read(vt[i], $sformatf("vec%0d", i), tw);
         else          run_write(vt[i], $sformatf("vec%0d", i), tw);
         @(negedge aclk);
      end

      // Concurrency: AW and AR presented together, both paths run independently
      vw = mkv(0, 16'h0C01, 40'h00_A000_0500, 1, 4, 1, 16'hFFFF, 16'h0008, 0, 0, 7, 40'h500, 40'h10, 2'd2);
      vr = mkv(1, 16'h0C02, 40'h00_A000_0600, 1, 4, 1, 16'hFFFF, 16'h0002, 0, 0, 3, 40'h600, 40'h10, 2'd0);
      clear_books();
      b_resp_cfg = vw.resps; r_resp_cfg = vr.resps; aw_dly_cfg = 0;
      fork
         run_write(vw, "conc_w", tw);
         run_read(vr, "conc_r", tr);
      join
      chk("conc same-cycle accept", tw, tr);
      @(negedge aclk);

      // Reset during beat 2 of a len=7 write
      clear_books();
      b_resp_cfg = 16'h0; aw_dly_cfg = 0;
      s_axi.awid = 16'h0D0D; s_axi.awaddr = BASE; s_axi.awlen = 8'd7;
      s_axi.awsize = 3'd4; s_axi.awburst = 2'b01; s_axi.awvalid = 1;
      @(negedge aclk); s_axi.awvalid = 0;
      for (int k = 0; k < 3; k++) begin
         s_axi.wdata = wd(k); s_axi.wstrb = 16'hFFFF; s_axi.wlast = 0; s_axi.wvalid = 1;
         n = 0;
         while (!s_axi.wready && n < TMO) begin @(negedge aclk); n++; end
         if (n >= TMO) chk("rst w timeout", 1, 0);
         @(negedge aclk); s_axi.wvalid = 0;
      end
      chk("rst pre lite valids", {m_axi.awvalid, m_axi.wvalid}, 2'b11);
      #2 aresetn = 0;
      #1;
      chk("rst valids cleared", {m_axi.awvalid, m_axi.wvalid, m_axi.arvalid, s_axi.bvalid, s_axi.rvalid}, 5'b0);
      chk("rst readies", {s_axi.awready, s_axi.arready, s_axi.wready, m_axi.bready, m_axi.rready}, 5'b11000);
      chk("rst addr/id cleared", {m_axi.awaddr, s_axi.bid}, 56'h0);
      repeat (2) @(negedge aclk);
      chk("rst no bvalid while held", s_axi.bvalid, 0);
      #2 aresetn = 1;
      @(negedge aclk);
      clear_books();
      vw = mkv(0, 16'h0E0E, 40'h00_A000_0080, 0, 4, 1, 16'hFFFF, 16'h0000, 0, 0, 4, 40'h80, 40'h10, 2'd0);
      b_resp_cfg = vw.resps;
      run_write(vw, "post_rst", tw);
      @(negedge aclk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/axi4_to_axil_bridge.md
# axi4_to_axil_bridge

Protocol converter between a full AXI4 slave port and an AXI4-Lite master port, with the same base-address rebasing (`m_addr = s_addr - DEC_S_ADDR`) as our passthrough address shim. Unlike that shim, it decomposes AXI4 bursts into single-beat Lite transactions, returns one merged write response per burst and regenerates `rid`/`rlast` on the read side. It sits between the PS high-performance port interconnect and Lite-only register/memory slaves in the PL.

## Interface
- `ADDR_W`, 40: address width on both sides.
- `DATA_W`, 128: data width on both sides; strobe width is `DATA_W/8`.
- `ID_W`, 16: AXI4 ID width.
- `DEC_S_ADDR`, 40'h00_A000_0000: base subtracted from every outgoing address.

Ports:
- `aclk` in 1: single clock.
- `aresetn` in 1: reset, asynchronous assertion, active-low.
- `s_axi_aw{id,addr,len,size,burst,valid,ready}`: AXI4 write address channel. Widths are ID_W / ADDR_W / 8 / 3 / 2 / 1 / 1. `ready` is an output.
- `s_axi_w{data,strb,last,valid,ready}`: AXI4 write data channel. Widths are DATA_W / DATA_W/8 / 1 / 1 / 1. `ready` is an output.
- `s_axi_b{id,resp,valid,ready}`: AXI4 write response channel. `ready` is an input; the others are outputs.
- `s_axi_ar*`, `s_axi_r{id,data,resp,last,valid,ready}`: AXI4 read channels, mirroring the write side.
- `m_axi_aw{addr,prot,valid,ready}`, `m_axi_w{data,strb,valid,ready}`, `m_axi_b{resp,valid,ready}`: AXI4-Lite write channels. `awprot` is tied to 3'b000.
- `m_axi_ar{addr,prot,valid,ready}`, `m_axi_r{data,resp,valid,ready}`: AXI4-Lite read channels.

AXI4 lock/cache/prot/qos/user inputs are not ported.

## Operation
- Write and read paths are independent FSMs. Each path handles one outstanding AXI4 transaction at a time. AW and AR may be accepted in the same cycle.

Write FSM: `W_IDLE → W_DATA → W_ISSUE → W_RESP → (W_DATA | W_BRESP) → W_IDLE`
- `W_IDLE`:
  - `s_axi_awready=1`.
  - On AW handshake, latch id, `addr-DEC_S_ADDR` (mod 2^ADDR_W), len, size and burst.
  - Clear beat counter and `acc_resp`, then go to `W_DATA`.
- `W_DATA`:
  - `s_axi_wready=1`.
  - On W handshake, register data/strb and go to `W_ISSUE`.
  - `s_axi_wlast` is ignored; the beat count comes from `awlen` only.
- `W_ISSUE`:
  - Assert `m_axi_awvalid` and `m_axi_wvalid` together.
  - Each valid drops independently after its own handshake.
  - Go to `W_RESP` when both handshakes are done, in either order or together.
- `W_RESP`:
  - `m_axi_bready=1`.
  - On B handshake, set `acc_resp = max(acc_resp, bresp)`, giving DECERR > SLVERR > OKAY.
  - If beat count equals len, go to `W_BRESP`. Otherwise increment the count, advance the address and return to `W_DATA`.
- `W_BRESP`:
  - `s_axi_bvalid=1` with the latched `bid` and `acc_resp`.
  - On handshake, go to `W_IDLE`.

Read FSM: `R_IDLE → R_ISSUE → R_WAIT → R_DATA → (R_ISSUE | R_IDLE)`
- `R_IDLE`: `s_axi_arready=1`; latch the same fields as the write side.
- `R_ISSUE`: `m_axi_arvalid=1` until handshake.
- `R_WAIT`: `m_axi_rready=1`; capture rdata/rresp on handshake.
- `R_DATA`:
  - `s_axi_rvalid=1` with the latched `rid`, captured data, and resp passed through per beat.
  - `s_axi_rlast=1` iff beat count equals len.
  - On handshake, return to `R_IDLE` if this was the last beat. Otherwise advance the address and go to `R_ISSUE`.

Address advance:
- INCR and WRAP: `addr += 1<<size`. WRAP is treated as INCR.
- FIXED: address unchanged.
- Addition wraps modulo 2^ADDR_W. 4 KB crossings are not checked.

## Timing
- Reset:
  - FSMs go to IDLE.
  - All `*valid` outputs are 0. All `m_*ready` outputs are 0.
  - `s_axi_awready` and `s_axi_arready` are 1.
  - Data, id, resp and addr outputs are 0.
- All outputs are decoded from registered state or registered data. There are no combinational paths from inputs to outputs.
- Write latency (zero-wait slave, `awlen=0`):
  - AW accepted in cycle 0; W accepted in cycle 1.
  - `m_awvalid`/`m_wvalid` high in cycle 2; `m_bready` in cycle 3.
  - `s_bvalid` in cycle 4.
  - Each further beat adds 3 cycles.
- Read latency (zero-wait slave): AR accepted in cycle 0, `m_arvalid` in cycle 1, `m_rready` in cycle 2, `s_rvalid` in cycle 3. Each further beat adds 3 cycles.
- Once asserted, every valid is held with stable payload until its handshake.
- `aresetn` low mid-burst aborts immediately. No partial B or R is emitted, and state is lost.

## Test plan
- Single write: AW `addr=40'h00_A000_0010`, len=0, size=4, `wdata=128'h1234`, slave OKAY → one Lite write at `40'h10` with strb intact; B `id` echoes, `resp=0`, `s_bvalid` in cycle 4.
- INCR write burst: len=3, size=4, base `0xA000_0000`, beat 2 slave returns SLVERR → Lite addrs 0x00/0x10/0x20/0x30; a single B with `resp=2`.
- FIXED read burst: len=2, `araddr=0xA000_0100`, id=0x5A → three Lite reads at 0x100; three R beats with `rid=0x5A`, `rlast` only on the third, per-beat rresp preserved.
- Backpressure: Lite `awready` asserted 3 cycles after `wready`, and `s_rready` low for 5 cycles → payload held stable, no beat lost or duplicated, counts correct.
- Concurrency: AW and AR in the same cycle with len=1 each → both paths complete independently; the ordering of Lite channels within each path is respected.
- Reset mid-burst: `aresetn` dropped during beat 2 of a len=7 write → all valids 0 immediately; after release, a fresh single write completes normally.
